// File: rtl/chime_pkg.sv
// Shared types and constants for the hourly chime receiver.
package chime_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chime_state_t;

  localparam int CHIME_HOUR_W      = 5;
  localparam int CHIME_FULL_DAY    = 24;
  localparam int CHIME_GAP_DEFAULT = 3;

  function automatic logic [CHIME_HOUR_W-1:0] sat_inc5(input logic [CHIME_HOUR_W-1:0] v);
    return (v == 5'd31) ? 5'd31 : v + 5'd1;
  endfunction

endpackage

// File: rtl/chime_gap_timer.sv
// Run-length counter for consecutive equal samples; term flags the GAP_CYCLES-th sample.
module chime_gap_timer
  import chime_pkg::*;
#(
  parameter int GAP_CYCLES = CHIME_GAP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic term
);

  localparam logic [3:0] GAP_C = 4'(GAP_CYCLES);

  logic [2:0] gap_cnt_r;

  // Run counter: clear beats load (first sample of a run), load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_r <= 3'd0;
    end else if (clr) begin
      gap_cnt_r <= 3'd0;
    end else if (load) begin
      gap_cnt_r <= 3'd1;
    end else if (inc && (gap_cnt_r != 3'd7)) begin
      gap_cnt_r <= gap_cnt_r + 3'd1;
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  // The sample being registered now would be the GAP_CYCLES-th of the run.
  assign term = (({1'b0, gap_cnt_r} + 4'd1) == GAP_C);

endmodule

// File: rtl/chime_decoder.sv
// Hourly chime pulse-train decoder: N pulses -> hour N, 24 pulses -> hour 0.
// Optional CHIME_STUCK_DET_EN aborts a burst whose line stays high for GAP_CYCLES samples.
module chime_decoder
  import chime_pkg::*;
#(
  parameter int GAP_CYCLES = CHIME_GAP_DEFAULT,
  parameter int MAX_PULSES = 24
) (
  input  logic                    CP_1Hz,
  input  logic                    nCR,
  input  logic                    chime_in,
  output logic [CHIME_HOUR_W-1:0] hour_out,
  output logic                    hour_valid,
  output logic                    busy,
  output logic                    chime_err
);

`ifdef CHIME_STUCK_DET_EN
  localparam logic STUCK_DET = 1'b1;
`else
  localparam logic STUCK_DET = 1'b0;
`endif

  localparam logic [CHIME_HOUR_W-1:0] MAX_C  = 5'(MAX_PULSES);
  localparam logic [CHIME_HOUR_W-1:0] FULL_C = 5'(CHIME_FULL_DAY);

  chime_state_t            state_r, state_nxt_s;
  logic [CHIME_HOUR_W-1:0] pulse_cnt_r, pulse_nxt_s, pulse_inc_s;
  logic [CHIME_HOUR_W-1:0] hour_r, hour_nxt_s;
  logic                    err_flag_r, err_nxt_s;
  logic                    valid_r, valid_nxt_s;
  logic                    cerr_r, cerr_nxt_s;
  logic                    busy_r;
  logic                    arm_r;
  logic                    abort_s;
  logic                    tmr_clr_s, tmr_load_s, tmr_inc_s, gap_term_s;

  assign pulse_inc_s = sat_inc5(pulse_cnt_r);

  chime_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk   (CP_1Hz),
    .rst_n (nCR),
    .clr   (tmr_clr_s),
    .load  (tmr_load_s),
    .inc   (tmr_inc_s),
    .term  (gap_term_s)
  );

  // Next-state, counter and strobe decode. With stuck detection the timer counts the high run.
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = pulse_cnt_r;
    err_nxt_s   = err_flag_r;
    hour_nxt_s  = hour_r;
    valid_nxt_s = 1'b0;
    cerr_nxt_s  = 1'b0;
    abort_s     = 1'b0;
    tmr_clr_s   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (chime_in && arm_r) begin
          pulse_nxt_s = 5'd1;
          state_nxt_s = HIGH;
          tmr_load_s  = STUCK_DET;
          tmr_clr_s   = !STUCK_DET;
        end else begin
          tmr_clr_s = 1'b1;
        end
      end
      HIGH: begin
        if (!chime_in) begin
          tmr_load_s  = 1'b1;
          state_nxt_s = LOW;
        end else if (STUCK_DET && gap_term_s) begin
          abort_s     = 1'b1;
          cerr_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
          pulse_nxt_s = 5'd0;
          err_nxt_s   = 1'b0;
          tmr_clr_s   = 1'b1;
        end else begin
          err_nxt_s = 1'b1;
          tmr_inc_s = STUCK_DET;
        end
      end
      LOW: begin
        if (chime_in) begin
          pulse_nxt_s = pulse_inc_s;
          err_nxt_s   = err_flag_r | (pulse_inc_s > MAX_C);
          tmr_load_s  = STUCK_DET;
          tmr_clr_s   = !STUCK_DET;
          state_nxt_s = HIGH;
        end else if (gap_term_s) begin
          state_nxt_s = IDLE;
          pulse_nxt_s = 5'd0;
          err_nxt_s   = 1'b0;
          tmr_clr_s   = 1'b1;
          if (err_flag_r) begin
            cerr_nxt_s = 1'b1;
          end else begin
            valid_nxt_s = 1'b1;
            hour_nxt_s  = (pulse_cnt_r == FULL_C) ? 5'd0 : pulse_cnt_r;
          end
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pulse_nxt_s = 5'd0;
        err_nxt_s   = 1'b0;
        tmr_clr_s   = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CP_1Hz or negedge nCR) begin
    if (!nCR) begin
      state_r     <= IDLE;
      pulse_cnt_r <= 5'd0;
      err_flag_r  <= 1'b0;
      hour_r      <= 5'd0;
      valid_r     <= 1'b0;
      cerr_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pulse_cnt_r <= pulse_nxt_s;
      err_flag_r  <= err_nxt_s;
      hour_r      <= hour_nxt_s;
      valid_r     <= valid_nxt_s;
      cerr_r      <= cerr_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // After a stuck-high abort, new bursts are refused until the line has been seen low.
  always_ff @(posedge CP_1Hz or negedge nCR) begin
    if (!nCR) begin
      arm_r <= 1'b1;
    end else if (abort_s) begin
      arm_r <= 1'b0;
    end else if (!chime_in) begin
      arm_r <= 1'b1;
    end else begin
      arm_r <= arm_r;
    end
  end

  assign hour_out   = hour_r;
  assign hour_valid = valid_r;
  assign chime_err  = cerr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_chime_decoder.sv
// Self-checking bench: bursts are described as pulse counts/gaps and expanded into
// a per-cycle schedule of expected strobes, busy and hour.
module tb_chime_decoder;

  localparam int GAP  = 3;
  localparam int MAXP = 24;

  logic       CP_1Hz = 1'b0;
  logic       nCR = 1'b0;
  logic       chime_in = 1'b0;
  logic [4:0] hour_out;
  logic       hour_valid, busy, chime_err;

  int n_tests = 0;
  int n_fail = 0;
  int model_hour = 0;

  bit wave_q[$];
  int ev_q[$];    // 0 none, 1 valid strobe, 2 error strobe
  bit busy_q[$];
  int hour_q[$];

  chime_decoder #(.GAP_CYCLES(GAP), .MAX_PULSES(MAXP)) dut (
    .CP_1Hz     (CP_1Hz),
    .nCR        (nCR),
    .chime_in   (chime_in),
    .hour_out   (hour_out),
    .hour_valid (hour_valid),
    .busy       (busy),
    .chime_err  (chime_err)
  );

  always #5 CP_1Hz = ~CP_1Hz;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit b);
    chime_in = b;
    @(posedge CP_1Hz);
    #1;
  endtask

  task automatic push(input bit b, input int ev, input bit bz);
    wave_q.push_back(b);
    ev_q.push_back(ev);
    busy_q.push_back(bz);
    hour_q.push_back(model_hour);
  endtask

  // gap=0 picks a random legal inter-pulse gap each time; w0 is the width of the first pulse.
  task automatic add_burst(input int lead, input int n, input int gap, input int w0, input int trail);
    int err;
    int g;
    err = ((n > MAXP) || (w0 > 1)) ? 1 : 0;
    for (int i = 0; i < lead; i++) push(1'b0, 0, 1'b0);
    for (int p = 0; p < n; p++) begin
      for (int w = 0; w < ((p == 0) ? w0 : 1); w++) push(1'b1, 0, 1'b1);
      if (p < n - 1) begin
        g = (gap > 0) ? gap : int'($urandom_range(GAP - 1, 1));
        for (int i = 0; i < g; i++) push(1'b0, 0, 1'b1);
      end
    end
    for (int i = 0; i < GAP - 1; i++) push(1'b0, 0, 1'b1);
    if (err == 0) model_hour = (n == 24) ? 0 : n;
    push(1'b0, (err != 0) ? 2 : 1, 1'b0);
    for (int i = 0; i < trail; i++) push(1'b0, 0, 1'b0);
  endtask

  task automatic play();
    bit b;
    bit bz;
    int ev;
    int h;
    while (wave_q.size() > 0) begin
      b  = wave_q.pop_front();
      ev = ev_q.pop_front();
      bz = busy_q.pop_front();
      h  = hour_q.pop_front();
      step(b);
      check("hour_valid", hour_valid, (ev == 1) ? 1 : 0);
      check("chime_err", chime_err, (ev == 2) ? 1 : 0);
      check("busy", busy, bz);
      check("hour_out", hour_out, h);
    end
  endtask

  initial begin
    #12;
    check("rst_hour", hour_out, 0);
    check("rst_valid", hour_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", chime_err, 0);
    @(negedge CP_1Hz);
    nCR = 1'b1;

    add_burst(1, 24, 1, 1, 0);  play();   // full day -> hour 0
    add_burst(0, 3, 1, 1, 1);   play();   // hour 3, back-to-back start
    add_burst(0, 25, 1, 1, 1);  play();   // over-long: error, hour kept
    add_burst(0, 3, GAP - 1, 1, 2); play(); // short gaps stay in one burst

    // Reset in the middle of a 12-pulse train.
    for (int i = 0; i < 5; i++) begin step(1'b1); step(1'b0); end
    check("mid_busy", busy, 1);
    #2 nCR = 1'b0;
    #1;
    model_hour = 0;
    check("arst_hour", hour_out, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", hour_valid, 0);
    check("arst_err", chime_err, 0);
    for (int i = 0; i < 4; i++) begin step(1'b1); step(1'b0); end
    check("inrst_busy", busy, 0);
    check("inrst_valid", hour_valid, 0);
    nCR = 1'b1;
    add_burst(0, 3, 1, 1, 2);   play();   // trailing pulses form their own burst
    add_burst(1, 7, 0, 1, 1);   play();

`ifdef CHIME_STUCK_DET_EN
    step(1'b1); step(1'b1);
    check("stuck_err_early", chime_err, 0);
    check("stuck_busy", busy, 1);
    step(1'b1);
    check("stuck_err", chime_err, 1);
    check("stuck_busy_off", busy, 0);
    check("stuck_valid", hour_valid, 0);
    step(1'b1);
    check("stuck_ignored", busy, 0);
    check("stuck_err_once", chime_err, 0);
    step(1'b0);
    add_burst(0, 1, 1, 1, 1);   play();
`else
    add_burst(0, 1, 1, 3, 1);   play();   // long high: error at gap timeout
    add_burst(0, 1, 1, 1, 1);   play();
`endif

    for (int r = 0; r < 30; r++) begin
      add_burst(int'($urandom_range(2, 0)), int'($urandom_range(27, 1)), 0,
                int'($urandom_range(2, 1)), int'($urandom_range(2, 0)));
      play();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
